// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: glitch-filtered clock, 11-bit frame check, watchdog abort and FWFT byte FIFO.
// Define PS2_RX_ERR_CNT_EN to add a saturating 16-bit error counter output (err_count).
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a start-bit falling edge while rx_en is high
// S_DATA  | shifting in bits 1..10, watchdog running
// S_CHECK | one cycle: validate frame, push byte or flag error/overflow
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rx_en,
  input  logic                          rd_en,
  input  logic                          clr_flags,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_done_tick,
  output logic                          frame_err_tick,
  output logic                          timeout_tick,
  output logic                          overflow
`ifdef PS2_RX_ERR_CNT_EN
  ,
  output logic [15:0]                   err_count
`endif
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  ps2c_f_q, ps2c_f_d;
  logic                  d_meta_q, d_sync_q;
  logic                  fall_edge;
  logic [10:0]           shreg_q, shreg_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic                  frame_good;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Filtered clock only changes when the whole window agrees; fall_edge looks one value ahead.
  always_comb begin
    filt_d   = {filt_q[FILTER_LEN-2:0], ps2c};
    ps2c_f_d = ps2c_f_q;
    if (&filt_q) begin
      ps2c_f_d = 1'b1;
    end else if (~|filt_q) begin
      ps2c_f_d = 1'b0;
    end
    fall_edge = ps2c_f_q & ~ps2c_f_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q   <= '1;
      ps2c_f_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      filt_q   <= filt_d;
      ps2c_f_q <= ps2c_f_d;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
    end
  end

  // Frame bits land LSB first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame_good = (shreg_q[0] == 1'b0) && (^shreg_q[9:1]) && shreg_q[10];

  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    bit_cnt_d       = bit_cnt_q;
    wd_d            = wd_q;
    push            = 1'b0;
    drop            = 1'b0;
    frame_done_tick = 1'b0;
    frame_err_tick  = 1'b0;
    timeout_tick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_edge && rx_en) begin
          shreg_d   = {d_sync_q, 10'd0};
          bit_cnt_d = 4'd1;
          wd_d      = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (fall_edge) begin
          shreg_d   = {d_sync_q, shreg_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          wd_d      = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d = S_CHECK;
          end
        end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          timeout_tick = 1'b1;
          bit_cnt_d    = 4'd0;
          wd_d         = '0;
          state_d      = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_CHECK: begin
        bit_cnt_d = 4'd0;
        state_d   = S_IDLE;
        if (frame_good) begin
          if (!full || rd_en) begin
            push            = 1'b1;
            frame_done_tick = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else begin
          frame_err_tick = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      wd_q      <= wd_d;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A push while full may proceed only alongside a pop, so overwriting the head slot is safe.
  always_comb begin
    pop        = rd_en & ~empty;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_flags) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shreg_q[8:1];
    end
  end

  assign overflow = overflow_q;

`ifdef PS2_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_flags) begin
      err_cnt_d = '0;
    end else if ((frame_err_tick || timeout_tick || drop) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised next-generation PS/2 serial receiver for keyboard/mouse input.
- Filters the PS/2 clock and deserialises 11-bit frames.
- Checks start, odd-parity and stop bits, and aborts stalled frames with a watchdog.
- Buffers good bytes in a first-word-fall-through FIFO, so the scan-code decoder downstream can pop at its own pace.

Parameters:
FILTER_LEN, 8, ps2c glitch-filter length in clk cycles (≥2)
FIFO_DEPTH, 16, byte FIFO depth (power of 2, ≥2)
TIMEOUT_CYCLES, 100000, clk cycles without a falling edge before an in-progress frame is aborted (2 ms at 50 MHz)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ps2c  input  1  raw PS/2 clock (asynchronous)
ps2d  input  1  raw PS/2 data (asynchronous)
rx_en  input  1  allow a new frame to start; does not abort a frame in progress
rd_en  input  1  pop FIFO head; ignored when empty
clr_flags  input  1  clears sticky overflow
dout  output  8  FIFO head byte; valid when empty=0
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  $clog2(FIFO_DEPTH)+1  bytes held
frame_done_tick  output  1  one-cycle pulse when a good byte is written
frame_err_tick  output  1  one-cycle pulse on bad start, parity or stop bit
timeout_tick  output  1  one-cycle pulse on watchdog abort
overflow  output  1  sticky: a good frame was dropped because the FIFO was full

Behaviour:
- Reset (async, reset_n=0):
  - filter shift register all ones; filtered clock = 1; ps2d 2-flop synchroniser = 1.
  - state = IDLE; bit counter 0; watchdog 0.
  - FIFO pointers 0; empty=1, full=0, count=0, dout=0.
  - All ticks 0; overflow=0.
- ps2c filter:
  - FILTER_LEN-bit shift register of ps2c.
  - Filtered clock goes to 1 when all bits are 1, to 0 when all bits are 0, else holds.
  - fall_edge = registered filtered clock 1 and next value 0; one cycle wide.
- ps2d passes through a 2-flop synchroniser and is sampled at fall_edge.
- State machine:
  - IDLE: on fall_edge and rx_en, shift in bit 0 (start), bit counter = 1, watchdog = 0, go to DATA. A fall_edge with rx_en=0 is ignored.
  - DATA: on fall_edge, shift in the bit (LSB first into an 11-bit register) and increment the counter. When the 11th bit is shifted in, go to CHECK.
  - DATA watchdog: increments every cycle without fall_edge and resets on fall_edge. Reaching TIMEOUT_CYCLES-1 → timeout_tick=1, go to IDLE, partial frame discarded.
  - CHECK (one cycle): frame good if start=0, XOR(data[7:0], parity)=1 and stop=1.
    - Good and (not full, or rd_en this cycle) → write byte, frame_done_tick=1.
    - Good and full without rd_en → drop byte, overflow=1.
    - Bad → frame_err_tick=1, nothing written.
    - Always return to IDLE.
- Latency: the fall_edge of the stop bit occurs in cycle N; CHECK is cycle N+1; empty=0 and dout valid in cycle N+2.
- FIFO (FWFT):
  - Pop on rd_en & ~empty. dout shows the new head the cycle after a pop.
  - Simultaneous push and pop: count unchanged. Allowed when full; the byte is accepted.
  - Push into empty with rd_en: the pop is ignored and the byte is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: cleared by clr_flags. If set and clear happen in the same cycle, set wins.
- A reset_n assertion mid-frame discards the frame and the FIFO contents immediately.

Optional Feature:
PS2_RX_ERR_CNT_EN:
- Defined: adds output err_count[15:0]. Increments on frame_err_tick, timeout_tick or an overflow drop; saturates at 16'hFFFF; cleared by clr_flags and by reset. Two error events cannot coincide by construction.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Send frame 0x1C with correct odd parity (parity=0), rx_en=1 → empty falls exactly 2 cycles after the stop-bit fall_edge, dout=0x1C, one frame_done_tick, count=1.
- Send 0xF0 with parity bit flipped → one frame_err_tick, empty stays 1, count=0.
- Send 0xAA then stop toggling ps2c after 5 bits → timeout_tick exactly TIMEOUT_CYCLES cycles after the last fall_edge; a following valid 0x55 is received correctly.
- Fill with 16 bytes 0x00..0x0F with no reads, then send 0x10 → full=1, overflow=1, 0x10 dropped. Read all 16 → data 0x00..0x0F in order, empty=1. Pulse clr_flags → overflow=0.
- 2-cycle low glitches on ps2c with FILTER_LEN=8 → no fall_edge, state stays IDLE. rx_en=0 during a whole frame → nothing received.
- Assert reset_n=0 mid-frame with 3 bytes queued → immediately empty=1, count=0, ticks 0. Next full frame 0x3A is received normally.
